// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: width codes, fault codes,
// FSM states, the latched bus request payload and store lane formatting.
package lsu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_width_e;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

   typedef enum logic {
      LSU_IDLE = 1'b0,
      LSU_BUSY = 1'b1
   } lsu_state_e;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } dbus_req_t;

   function automatic logic load_f3_ok(input logic [2:0] f3);
      return (f3 == MEM_B) || (f3 == MEM_H) || (f3 == MEM_W) ||
             (f3 == MEM_BU) || (f3 == MEM_HU);
   endfunction

   function automatic logic store_f3_ok(input logic [2:0] f3);
      return (f3 == MEM_B) || (f3 == MEM_H) || (f3 == MEM_W);
   endfunction

   // Loads and stores share the enable pattern; f3[1:0] carries the size.
   function automatic logic [BE_W-1:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return BE_W'(4'b0001 << off);
         2'b01:   return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] sd);
      case (f3[1:0])
         2'b00:   return {4{sd[7:0]}};
         2'b01:   return {2{sd[15:0]}};
         default: return sd;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a bus read word.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      offset_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata_i[{offset_i, 3'b000} +: 8];
      half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         MEM_B:   data_o = {{24{byte_v[7]}}, byte_v};
         MEM_BU:  data_o = {24'h0, byte_v};
         MEM_H:   data_o = {{16{half_v[15]}}, half_v};
         MEM_HU:  data_o = {16'h0, half_v};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one req/ack data-bus transaction per load/store,
// stalls upstream while busy and reports misaligned, illegal and timed-out ops.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] store_data,
   input  logic [4:0]      rd_in,
   output logic            stall,
   output logic            dbus_req,
   output logic            dbus_we,
   output logic [XLEN-1:0] dbus_addr,
   output logic [BE_W-1:0] dbus_be,
   output logic [XLEN-1:0] dbus_wdata,
   input  logic            dbus_ack,
   input  logic [XLEN-1:0] dbus_rdata,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            fault,
   output logic [1:0]      fault_code
);

   localparam int unsigned     CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit              TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dbus_req_t        req_q, req_d;
   logic [2:0]       f3_q, f3_d;
   logic [4:0]       rd_q, rd_d;
   logic             wb_valid_q, wb_valid_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]  wb_data_q, wb_data_d;
   logic             fault_q, fault_d;
   logic [1:0]       fault_code_q, fault_code_d;
   logic             stall_c;

   logic            op_valid, illegal, misalign;
   logic [XLEN-1:0] load_data;

   lsu_load_align u_align (
      .rdata_i  (dbus_rdata),
      .offset_i (req_q.addr[1:0]),
      .funct3_i (f3_q),
      .data_o   (load_data)
   );

   // Legality checks apply to the op presented in IDLE; illegal wins over misaligned.
   always_comb begin
      op_valid = ex_valid && (mem_read || mem_write);
      illegal  = (mem_read && mem_write) ||
                 (mem_read && !load_f3_ok(funct3)) ||
                 (mem_write && !store_f3_ok(funct3));
      misalign = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                 ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      f3_d         = f3_q;
      rd_d         = rd_q;
      wb_valid_d   = 1'b0;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      fault_d      = 1'b0;
      fault_code_d = FAULT_NONE;
      stall_c      = 1'b0;
      case (state_q)
         LSU_IDLE: begin
            if (op_valid) begin
               if (illegal) begin
                  fault_d      = 1'b1;
                  fault_code_d = FAULT_ILLEGAL;
               end else if (misalign) begin
                  fault_d      = 1'b1;
                  fault_code_d = FAULT_MISALIGN;
               end else begin
                  state_d     = LSU_BUSY;
                  cnt_d       = '0;
                  req_d.we    = mem_write;
                  req_d.addr  = alu_result;
                  req_d.be    = byte_en(funct3, alu_result[1:0]);
                  req_d.wdata = mem_write ? store_lanes(funct3, store_data) : '0;
                  f3_d        = funct3;
                  rd_d        = rd_in;
                  stall_c     = 1'b1;
               end
            end
         end
         LSU_BUSY: begin
            stall_c = !dbus_ack;
            // Ack takes priority over a timeout landing on the same cycle.
            if (dbus_ack) begin
               state_d = LSU_IDLE;
               cnt_d   = '0;
               if (!req_q.we) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = rd_q;
                  wb_data_d  = load_data;
               end
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               state_d      = LSU_IDLE;
               cnt_d        = '0;
               fault_d      = 1'b1;
               fault_code_d = FAULT_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= LSU_IDLE;
         cnt_q        <= '0;
         req_q        <= '0;
         f3_q         <= '0;
         rd_q         <= '0;
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         fault_q      <= 1'b0;
         fault_code_q <= FAULT_NONE;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         f3_q         <= f3_d;
         rd_q         <= rd_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   assign stall      = stall_c;
   assign dbus_req   = (state_q == LSU_BUSY);
   assign dbus_we    = req_q.we;
   assign dbus_addr  = {req_q.addr[XLEN-1:2], 2'b00};
   assign dbus_be    = req_q.be;
   assign dbus_wdata = req_q.wdata;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4): inputs driven on the falling
// edge, outputs checked 1ns later against hand-computed values.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] alu_result, store_data;
   logic [4:0]  rd_in;
   logic        stall, dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_be;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        fault;
   logic [1:0]  fault_code;

   int n_cmp = 0;
   int n_bad = 0;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
      .store_data(store_data), .rd_in(rd_in), .stall(stall), .dbus_req(dbus_req),
      .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
      .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault),
      .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
      ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
      alu_result = a; store_data = sd; rd_in = r;
      #1;
   endtask

   task automatic clear_op();
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      funct3 = 3'b000; alu_result = '0; store_data = '0; rd_in = '0;
   endtask

   // Present ack for one cycle with the given read word; stall must be low that cycle.
   task automatic ack_cycle(input logic [31:0] rdata, input string tag);
      dbus_ack = 1'b1; dbus_rdata = rdata;
      #1;
      chk({tag, "_stall_at_ack"}, 32'(stall), 32'd0);
      next_cycle();
      dbus_ack = 1'b0; dbus_rdata = '0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clear_op();
      dbus_ack = 1'b0; dbus_rdata = '0;
      repeat (2) next_cycle();
      rst = 1'b0;
      #1;
      chk("rst_req",   32'(dbus_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wbv",   32'(wb_valid), 32'd0);
      chk("rst_wbd",   wb_data, 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_code",  32'(fault_code), 32'd0);

      // LW 0x1000, ack on the fourth BUSY cycle (counter at the timeout limit: ack wins)
      next_cycle();
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 5'd5);
      chk("lw_accept_stall", 32'(stall), 32'd1);
      chk("lw_accept_req",   32'(dbus_req), 32'd0);
      next_cycle();
      clear_op();
      #1;
      chk("lw_req",   32'(dbus_req), 32'd1);
      chk("lw_we",    32'(dbus_we), 32'd0);
      chk("lw_addr",  dbus_addr, 32'h0000_1000);
      chk("lw_be",    32'(dbus_be), 32'hF);
      chk("lw_stall", 32'(stall), 32'd1);
      next_cycle(); #1;
      chk("lw_stall_b1", 32'(stall), 32'd1);
      next_cycle(); #1;
      chk("lw_stall_b2", 32'(stall), 32'd1);
      next_cycle();
      chk("lw_req_b3", 32'(dbus_req), 32'd1);
      ack_cycle(32'hDEAD_BEEF, "lw");
      chk("lw_wbv",   32'(wb_valid), 32'd1);
      chk("lw_wbd",   wb_data, 32'hDEAD_BEEF);
      chk("lw_wbrd",  32'(wb_rd), 32'd5);
      chk("lw_req_done", 32'(dbus_req), 32'd0);
      chk("lw_nofault",  32'(fault), 32'd0);
      next_cycle(); #1;
      chk("lw_wbv_pulse", 32'(wb_valid), 32'd0);
      chk("lw_wbd_hold",  wb_data, 32'hDEAD_BEEF);

      // LB 0x1003 then back-to-back LBU 0x1003, then LH 0x1002
      drive_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7);
      next_cycle(); clear_op(); #1;
      chk("lb_be",   32'(dbus_be), 32'h8);
      chk("lb_addr", dbus_addr, 32'h0000_1000);
      ack_cycle(32'h80FF_0000, "lb");
      chk("lb_wbv", 32'(wb_valid), 32'd1);
      chk("lb_wbd", wb_data, 32'hFFFF_FF80);
      chk("lb_wbrd", 32'(wb_rd), 32'd7);
      drive_op(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd8);
      chk("b2b_stall", 32'(stall), 32'd1);
      next_cycle(); clear_op(); #1;
      chk("lbu_req", 32'(dbus_req), 32'd1);
      chk("lbu_be",  32'(dbus_be), 32'h8);
      ack_cycle(32'h80FF_0000, "lbu");
      chk("lbu_wbd", wb_data, 32'h0000_0080);
      chk("lbu_wbrd", 32'(wb_rd), 32'd8);
      next_cycle();
      drive_op(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 5'd9);
      next_cycle(); clear_op(); #1;
      chk("lh_be", 32'(dbus_be), 32'hC);
      ack_cycle(32'h80FF_0000, "lh");
      chk("lh_wbv", 32'(wb_valid), 32'd1);
      chk("lh_wbd", wb_data, 32'hFFFF_80FF);

      // SB 0x2001 and SH 0x2002: replicated lanes, no writeback
      next_cycle();
      drive_op(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h1234_5678, 5'd3);
      next_cycle(); clear_op(); #1;
      chk("sb_we",    32'(dbus_we), 32'd1);
      chk("sb_addr",  dbus_addr, 32'h0000_2000);
      chk("sb_be",    32'(dbus_be), 32'h2);
      chk("sb_wdata", dbus_wdata, 32'h7878_7878);
      ack_cycle(32'h0, "sb");
      chk("sb_no_wbv", 32'(wb_valid), 32'd0);
      chk("sb_wbd_hold", wb_data, 32'hFFFF_80FF);
      next_cycle();
      drive_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 5'd3);
      next_cycle(); clear_op(); #1;
      chk("sh_be",    32'(dbus_be), 32'hC);
      chk("sh_wdata", dbus_wdata, 32'h5678_5678);
      ack_cycle(32'h0, "sh");
      chk("sh_no_wbv", 32'(wb_valid), 32'd0);
      chk("sh_wbrd_hold", 32'(wb_rd), 32'd9);

      // Misaligned LW, then illegal read+write, illegal load and store widths
      next_cycle();
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 5'd1);
      chk("mis_stall", 32'(stall), 32'd0);
      next_cycle(); clear_op(); #1;
      chk("mis_req",   32'(dbus_req), 32'd0);
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_code",  32'(fault_code), 32'd1);
      chk("mis_no_wbv", 32'(wb_valid), 32'd0);
      drive_op(1'b1, 1'b1, 3'b000, 32'h0000_1000, 32'h0, 5'd1);
      chk("ill_rw_stall", 32'(stall), 32'd0);
      next_cycle(); clear_op(); #1;
      chk("ill_rw_fault", 32'(fault), 32'd1);
      chk("ill_rw_code",  32'(fault_code), 32'd2);
      chk("ill_rw_req",   32'(dbus_req), 32'd0);
      drive_op(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0, 5'd1);
      next_cycle(); clear_op(); #1;
      chk("ill_ld_code", 32'(fault_code), 32'd2);
      drive_op(1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'h0, 5'd1);
      next_cycle(); clear_op(); #1;
      chk("ill_st_code", 32'(fault_code), 32'd2);
      next_cycle(); #1;
      chk("fault_pulse", 32'(fault), 32'd0);

      // Ack while IDLE is ignored
      dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
      next_cycle();
      dbus_ack = 1'b0; dbus_rdata = '0;
      #1;
      chk("idle_ack_wbv",   32'(wb_valid), 32'd0);
      chk("idle_ack_fault", 32'(fault), 32'd0);

      // Timeout: request held exactly 4 cycles, then fault 11, then normal op
      drive_op(1'b0, 1'b1, 3'b010, 32'h0000_3000, 32'hA5A5_A5A5, 5'd2);
      next_cycle(); clear_op(); #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("to_req_%0d", i), 32'(dbus_req), 32'd1);
         next_cycle(); #1;
      end
      chk("to_req_drop", 32'(dbus_req), 32'd0);
      chk("to_fault",    32'(fault), 32'd1);
      chk("to_code",     32'(fault_code), 32'd3);
      chk("to_stall",    32'(stall), 32'd0);
      drive_op(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 5'd12);
      next_cycle(); clear_op(); #1;
      chk("post_to_req", 32'(dbus_req), 32'd1);
      ack_cycle(32'h80FF_0000, "post_to");
      chk("lhu_wbd",  wb_data, 32'h0000_80FF);
      chk("lhu_wbrd", 32'(wb_rd), 32'd12);

      // Asynchronous reset mid-BUSY discards the op
      next_cycle();
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd4);
      next_cycle(); clear_op(); #1;
      chk("rb_req", 32'(dbus_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rb_req_async", 32'(dbus_req), 32'd0);
      dbus_ack = 1'b1; dbus_rdata = 32'h1111_1111;
      next_cycle();
      rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
      #1;
      chk("rb_wbv",   32'(wb_valid), 32'd0);
      chk("rb_fault", 32'(fault), 32'd0);
      chk("rb_wbd",   wb_data, 32'd0);
      next_cycle(); #1;
      chk("rb_wbv2",  32'(wb_valid), 32'd0);
      chk("rb_fault2", 32'(fault), 32'd0);
      chk("rb_req2",  32'(dbus_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Takes ALUResult as the effective address and runs a req/ack data-bus transaction: byte enables, store-lane replication, and load alignment/extension.
- Produces writeback data and stalls upstream while the bus is busy.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT, 255, max BUSY cycles without dbus_ack before abort; 0 disables timeout
CNT_W, $clog2(TIMEOUT+1) (min 1), timeout counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
ex_valid  in  1  memory op presented this cycle
mem_read  in  1  op is a load
mem_write  in  1  op is a store
funct3  in  3  RV32I width code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
alu_result  in  32  effective address
store_data  in  32  rs2 value
rd_in  in  5  load destination register
stall  out  1  hold upstream stages
dbus_req  out  1  bus request
dbus_we  out  1  1 = write
dbus_addr  out  32  word-aligned address {addr[31:2],2'b00}
dbus_be  out  4  byte enables
dbus_wdata  out  32  lane-replicated store data
dbus_ack  in  1  single-cycle completion
dbus_rdata  in  32  read word, valid with ack
wb_valid  out  1  load result valid (1-cycle pulse)
wb_rd  out  5  destination register
wb_data  out  32  aligned, extended load data
fault  out  1  1-cycle fault pulse
fault_code  out  2  01 misaligned, 10 illegal, 11 timeout

Behaviour:
- Reset values: state IDLE; counter 0; all outputs 0.
- Reset is asynchronous: mid-transaction it drops dbus_req immediately and discards the op; no wb_valid or fault.
- States:
  - IDLE: accept when ex_valid && (mem_read | mem_write).
  - BUSY: dbus_req=1; addr/we/be/wdata/funct3/rd stable, latched at accept.
- Illegal op (checked first, in IDLE, no bus activity, stay IDLE, stall=0; fault/fault_code registered and pulse next cycle):
  - mem_read && mem_write; or
  - load funct3 in {011,110,111}; or
  - store funct3 not in {000,001,010}.
  - Result: fault_code 10.
- Misaligned op (same handling as illegal): H with addr[0]=1, or W with addr[1:0]!=0. Result: fault_code 01.
- Legal accept:
  - Latch fields, go BUSY next edge.
  - stall=1 combinationally in the accept cycle.
- BUSY:
  - stall = !dbus_ack.
  - Counter increments each cycle without ack.
  - On dbus_ack: go IDLE; counter to 0.
  - Load ack: wb_valid=1, wb_rd, wb_data registered; visible the cycle after ack.
  - Store ack: no wb_valid.
- Timeout: TIMEOUT!=0 and counter==TIMEOUT-1 with no ack:
  - Abort: req drops next edge, go IDLE, fault=1 with code 11 next cycle, stall drops.
  - An ack on the same cycle wins over the timeout.
- Back-to-back: a new op may be accepted in the first IDLE cycle after ack, so minimum 2 cycles per access (accept + ack cycle).
- dbus_ack in IDLE is ignored.
- Store byte enables and data:
  - SB: be = 1<<addr[1:0]; wdata = byte replicated x4.
  - SH: be = addr[1] ? 1100 : 0011; wdata = half replicated x2.
  - SW: be = 1111; wdata = store_data.
- Loads: read be uses the same enable rules as stores.
  - LB/LBU select lane addr[1:0].
  - LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- wb_data and wb_rd hold their values after wb_valid falls, until the next load completes.

Decomposition:
- lsu_pkg holds:
  - funct3 width enum: MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU.
  - fault code constants: FAULT_NONE, FAULT_MISALIGN, FAULT_ILLEGAL, FAULT_TIMEOUT.
  - state enum: LSU_IDLE, LSU_BUSY.
- One combinational sub-module, lsu_load_align(rdata, offset[1:0], funct3 -> data): lane select and extension, unit-testable alone.

Test Plan:
- LW from 0x1000, ack 3 cycles after req with rdata 0xDEADBEEF -> dbus_addr 0x1000, be 1111; stall high until the ack cycle; wb_valid the cycle after ack with wb_data 0xDEADBEEF and wb_rd = rd_in.
- LB/LBU from 0x1003, rdata 0x80FF_0000 -> be 1000; LB gives wb_data 0xFFFFFF80, LBU gives 0x00000080. LH from 0x1002 gives 0xFFFF80FF.
- SB to 0x2001 with store_data 0x12345678 -> dbus_we 1, be 0010, wdata 0x78787878. SH to 0x2002 -> be 1100, wdata 0x56785678. No wb_valid after ack.
- LW from 0x1002 -> no dbus_req, stall 0; fault=1 with code 01 next cycle. mem_read=mem_write=1 -> fault code 10.
- TIMEOUT=4, no ack -> dbus_req high exactly 4 cycles; fault code 11; back to IDLE; next op accepted normally.
- rst asserted mid-BUSY -> dbus_req drops without a clock edge; no wb_valid or fault afterwards.
